reg_status_file: RTL

- Architectural register file with per-register rename tags. It is the commit-side receiver and decode-side source for the reorder buffer.
- Decode reads source values and tags here. A non-zero tag sends the reader to the ROB entry with that index.
- Each dispatched instruction renames its destination to its ROB index.
- ROB commits write values back and clear the matching tag. Rollback discards all in-flight tags.

---
 rtl/reg_status_file_pkg.sv | 27 ++
 rtl/reg_status_file.sv | 118 +++++++++++
 2 files changed

// File: rtl/reg_status_file_pkg.sv
// Shared sizes, tag constants and types for the architectural register/status file
// that sits between decode (rename) and the reorder buffer (commit).
package reg_status_file_pkg;

  localparam int ROB_IDX_W  = 4;
  localparam int REG_NUM    = 32;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = $clog2(REG_NUM);
  localparam int CNT_W      = 6;

  // ROB indices are 1-based; index 0 means "value lives in the register file".
  localparam int ROB_ENTRY_NUM = 2**ROB_IDX_W - 1;

  typedef logic [ROB_IDX_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  localparam tag_t      NULL_TAG = '0;
  localparam reg_addr_t REG_ZERO = '0;

  typedef struct packed {
    data_t data;
    tag_t  tag;
  } rd_result_t;

endpackage

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename tags: two combinational read
// ports with commit bypass, one rename port, one in-order commit port and a rollback.
module reg_status_file
  import reg_status_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rollback,
  input  reg_addr_t raddr1,
  output data_t     rdata1,
  output tag_t      rtag1,
  input  reg_addr_t raddr2,
  output data_t     rdata2,
  output tag_t      rtag2,
  input  logic      rename_en,
  input  reg_addr_t rename_addr,
  input  tag_t      rename_tag,
  input  logic      commit_we,
  input  reg_addr_t commit_addr,
  input  data_t     commit_data,
  input  tag_t      commit_tag,
  output cnt_t      busy_cnt
);

  data_t [REG_NUM-1:0] value_q, value_d;
  tag_t  [REG_NUM-1:0] tag_q,   tag_d;
  cnt_t                busy_cnt_q, busy_cnt_d;

  logic commit_hit;
  logic clear_hit;
  logic rename_hit;
  logic busy_inc;
  logic busy_dec;

  // A clear only counts when no same-cycle rename re-tags that register.
  always_comb begin
    commit_hit = commit_we && (commit_addr != REG_ZERO);
    clear_hit  = commit_hit && (commit_tag != NULL_TAG) &&
                 (tag_q[commit_addr] == commit_tag);
    rename_hit = rename_en && !rollback &&
                 (rename_addr != REG_ZERO) && (rename_tag != NULL_TAG);
    busy_inc   = rename_hit && (tag_q[rename_addr] == NULL_TAG);
    busy_dec   = clear_hit && !(rename_hit && (rename_addr == commit_addr));
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no branch can infer a latch.
    value_d    = value_q;
    tag_d      = tag_q;
    busy_cnt_d = busy_cnt_q + cnt_t'(busy_inc) - cnt_t'(busy_dec);

    if (commit_hit) value_d[commit_addr] = commit_data;
    if (clear_hit)  tag_d[commit_addr]   = NULL_TAG;
    if (rename_hit) tag_d[rename_addr]   = rename_tag;

    if (rollback) begin
      tag_d      = '0;
      busy_cnt_d = '0;
    end

    value_d[0] = '0;
    tag_d[0]   = NULL_TAG;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the value array is reset too, because software may read any register
      // straight after reset and must see zero.
      value_q    <= '0;
      tag_q      <= '0;
      busy_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge state.
      value_q    <= value_d;
      tag_q      <= tag_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  reg_addr_t  [1:0] raddr_a;
  rd_result_t [1:0] rd_a;

  assign raddr_a = {raddr2, raddr1};

  for (genvar g = 0; g < 2; g++) begin : gen_rd
    rd_result_t rd;

    // Rename is deliberately invisible here: a reader sees pre-rename state.
    always_comb begin
      rd.data = value_q[raddr_a[g]];
      rd.tag  = tag_q[raddr_a[g]];
      if (commit_we && (commit_addr == raddr_a[g])) begin
        rd.data = commit_data;
        if (tag_q[raddr_a[g]] == commit_tag) rd.tag = NULL_TAG;
      end
      if (raddr_a[g] == REG_ZERO) rd = '0;
    end

    assign rd_a[g] = rd;
  end

  assign rdata1 = rd_a[0].data;
  assign rtag1  = rd_a[0].tag;
  assign rdata2 = rd_a[1].data;
  assign rtag2  = rd_a[1].tag;

  a_commit_tag_nonzero: assert property (@(posedge clk) disable iff (!rst)
    commit_we |-> (commit_tag != NULL_TAG));

  a_rename_tag_range: assert property (@(posedge clk) disable iff (!rst)
    rename_en |-> (int'(rename_tag) <= ROB_ENTRY_NUM));

  a_busy_bound: assert property (@(posedge clk)
    int'(busy_cnt_q) <= REG_NUM - 1);

endmodule
